// File: rtl/iu_sched.sv
// iu_sched: shares one multi-cycle PC predictor among NREQ fetch requesters.
//
// Incoming requests are arbitrated (miss redirects first, then round-robin).
// The winner is sequenced through the predictor's ISSUE/WAIT phases, and the
// predicted PC is returned to it. If the predictor stays silent for TIMEOUT
// WAIT cycles, a fallback of pc+4 is returned with resp_err set.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/miss    per-requester request and mispredict-redirect flag
//   req_pc            packed per-requester PCs, slice i = [i*XLEN +: XLEN]
//   req_ready         one-hot grant, combinational in the accept cycle
//   resp_valid        one-hot one-cycle response strobe
//   resp_pc/resp_err  response payload, zero when no response is active
//   pr_start          one-cycle start pulse to the predictor
//   pr_miss/pc_curr   latched request, held from ISSUE through RESP
//   pr_pc_pre(_oe)    predictor result and its valid
module iu_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_miss,
    input  logic [NREQ*XLEN-1:0] req_pc,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [XLEN-1:0]      resp_pc,
    output logic                 resp_err,
    output logic                 pr_start,
    output logic                 pr_miss,
    output logic [XLEN-1:0]      pr_pc_curr,
    input  logic [XLEN-1:0]      pr_pc_pre,
    input  logic                 pr_pc_pre_oe
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   win;
    logic            win_found;
    logic [NREQ-1:0] cand;
    logic [XLEN-1:0] lat_pc;
    logic            lat_miss;
    logic [XLEN-1:0] res_pc;
    logic            res_err;
    logic [7:0]      cnt;
    logic            timeout_hit;

    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    // Miss redirects form the candidate class whenever any is present;
    // the round-robin scan starts at rr and wraps modulo NREQ.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        cand      = (|(req_valid & req_miss)) ? (req_valid & req_miss) : req_valid;
        win       = '0;
        win_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr) + k) % NREQ;
            if (!win_found && cand[idx]) begin
                win       = IW'(idx);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_found) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (pr_pc_pre_oe || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= '0;
            owner    <= '0;
            lat_pc   <= '0;
            lat_miss <= 1'b0;
            res_pc   <= '0;
            res_err  <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        owner    <= win;
                        lat_pc   <= req_pc[32'(win)*XLEN +: XLEN];
                        lat_miss <= req_miss[win];
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // A result arriving on the timeout cycle takes precedence.
                    if (pr_pc_pre_oe) begin
                        res_pc  <= pr_pc_pre;
                        res_err <= 1'b0;
                    end else if (timeout_hit) begin
                        res_pc  <= lat_pc + XLEN'(4);
                        res_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (owner == IW'(NREQ - 1)) rr <= '0;
                    else                        rr <= owner + IW'(1);
                end
                default: ;
            endcase
        end
    end

    // req_ready is gated by rst_n: a grant shown while reset holds the
    // flops would be silently lost.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (state == IDLE && win_found && rst_n) req_ready[win] = 1'b1;
        if (state == RESP) resp_valid[owner] = 1'b1;
    end

    assign resp_pc    = (state == RESP) ? res_pc : '0;
    assign resp_err   = (state == RESP) ? res_err : 1'b0;
    assign pr_start   = (state == ISSUE);
    assign pr_miss    = (state != IDLE) ? lat_miss : 1'b0;
    assign pr_pc_curr = (state != IDLE) ? lat_pc : '0;

endmodule

// File: tb/tb_iu_sched.sv
module tb_iu_sched;

    localparam int NREQ    = 4;
    localparam int XLEN    = 64;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_miss, req_ready, resp_valid;
    logic [255:0] req_pc;
    logic [63:0]  resp_pc, pr_pc_curr, pr_pc_pre;
    logic         resp_err, pr_start, pr_miss, pr_pc_pre_oe;

    always #5 clk = ~clk;

    iu_sched #(.NREQ(NREQ), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_miss(req_miss), .req_pc(req_pc),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_pc(resp_pc),
        .resp_err(resp_err), .pr_start(pr_start), .pr_miss(pr_miss),
        .pr_pc_curr(pr_pc_curr), .pr_pc_pre(pr_pc_pre), .pr_pc_pre_oe(pr_pc_pre_oe)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // requester drive state
    logic [3:0]  v, m;
    logic [63:0] pcs [4];

    // transaction-level model of the scheduler
    bit          busy;
    int          t_acc, own, rr, resp_c;
    logic [63:0] mpc, rpc;
    bit          mmiss, resolved, rerr;

    // stub predictor and test knobs
    int          fire_c, lat_cfg, stray_mode;
    logic [63:0] fire_val;
    bit          plus4, rereq, rand_mode;

    // observations
    int          gq[$];
    int          last_acc_c, last_resp_c, resp_count;
    logic [63:0] last_resp_pc;
    bit          last_resp_err;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] vv, input logic [3:0] mm, input int r);
        logic [3:0] c;
        c = (|(vv & mm)) ? (vv & mm) : vv;
        for (int k = 0; k < 4; k++)
            if (c[(r + k) % 4]) return (r + k) % 4;
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, 64'(req_ready), 64'd0);
        check_val({tag, "_rv"}, 64'(resp_valid), 64'd0);
        check_val({tag, "_rpc"}, resp_pc, 64'd0);
        check_val({tag, "_rerr"}, 64'(resp_err), 64'd0);
        check_val({tag, "_start"}, 64'(pr_start), 64'd0);
        check_val({tag, "_miss"}, 64'(pr_miss), 64'd0);
        check_val({tag, "_pcc"}, pr_pc_curr, 64'd0);
    endtask

    // Asserts reset asynchronously wherever the caller is in the cycle.
    task automatic apply_reset();
        v = '0; m = '0;
        req_valid = '0; req_miss = '0; pr_pc_pre_oe = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busy = 0; rr = 0; fire_c = -1; resolved = 0;
        gq.delete();
    endtask

    task automatic step();
        int          w, d, lat;
        logic        oe;
        logic [63:0] pre;
        logic [3:0]  e_rdy, e_rv;
        logic [63:0] e_rpc, e_pcc;
        logic        e_err, e_st, e_miss;

        @(negedge clk);
        if (rand_mode)
            for (int i = 0; i < 4; i++)
                if (!v[i] && $urandom_range(0, 5) == 0) begin
                    v[i]   = 1'b1;
                    m[i]   = ($urandom_range(0, 3) == 0);
                    pcs[i] = {$urandom, $urandom};
                end
        oe  = 1'b0;
        pre = {$urandom, $urandom};
        if (busy && cyc == fire_c) begin
            oe  = 1'b1;
            pre = fire_val;
        end else if ((stray_mode == 1 && !busy) || stray_mode == 2) begin
            if ($urandom_range(0, 6) == 0) oe = 1'b1;
        end
        req_valid = v;
        req_miss  = m;
        for (int i = 0; i < 4; i++) req_pc[i*64 +: 64] = pcs[i];
        pr_pc_pre_oe = oe;
        pr_pc_pre    = pre;
        #1;

        e_rdy = '0; e_rv = '0; e_rpc = '0; e_pcc = '0;
        e_err = 0; e_st = 0; e_miss = 0;
        w = -1; d = 0;
        if (!busy) begin
            if (|v) begin
                w = pick(v, m, rr);
                e_rdy[w] = 1'b1;
            end
        end else begin
            d      = cyc - t_acc;
            e_st   = (d == 1);
            e_miss = mmiss;
            e_pcc  = mpc;
            if (resolved && cyc == resp_c) begin
                e_rv[own] = 1'b1;
                e_rpc     = rpc;
                e_err     = rerr;
            end
        end
        check_val("req_ready", 64'(req_ready), 64'(e_rdy));
        check_val("resp_valid", 64'(resp_valid), 64'(e_rv));
        check_val("resp_pc", resp_pc, e_rpc);
        check_val("resp_err", 64'(resp_err), 64'(e_err));
        check_val("pr_start", 64'(pr_start), 64'(e_st));
        check_val("pr_miss", 64'(pr_miss), 64'(e_miss));
        check_val("pr_pc_curr", pr_pc_curr, e_pcc);

        for (int i = 0; i < 4; i++) if (req_ready[i]) gq.push_back(i);
        if (resp_valid != 0) begin
            last_resp_c   = cyc;
            last_resp_pc  = resp_pc;
            last_resp_err = resp_err;
            resp_count++;
        end

        if (!busy) begin
            if (w >= 0) begin
                busy = 1; t_acc = cyc; own = w; mpc = pcs[w]; mmiss = m[w];
                resolved = 0; last_acc_c = cyc;
                lat = rand_mode ? int'($urandom_range(0, TIMEOUT + 2)) : lat_cfg;
                fire_c   = (lat > 0) ? cyc + 1 + lat : -1;
                fire_val = plus4 ? pcs[w] + 64'd4 : {$urandom, $urandom};
                v[w] = rereq;
            end
        end else if (resolved && cyc == resp_c) begin
            busy = 0;
            rr   = (own + 1) % 4;
        end else if (!resolved && d >= 2) begin
            if (oe) begin
                resolved = 1; resp_c = cyc + 1; rpc = pre; rerr = 0;
            end else if (d == 1 + TIMEOUT) begin
                resolved = 1; resp_c = cyc + 1; rpc = mpc + 64'd4; rerr = 1;
            end
        end
        cyc++;
    endtask

    initial begin
        int rc0;
        v = '0; m = '0; req_pc = '0; pr_pc_pre = '0;
        for (int i = 0; i < 4; i++) pcs[i] = '0;
        stray_mode = 0; plus4 = 1; rereq = 0; rand_mode = 0; lat_cfg = 1;
        resp_count = 0; last_acc_c = 0; last_resp_c = 0;
        last_resp_pc = '0; last_resp_err = 0;
        apply_reset();

        // single request, 6-cycle predictor returning pc+4
        lat_cfg = 6; plus4 = 1;
        pcs[2] = 64'h1000; v = 4'b0100;
        repeat (12) step();
        check_val("single_n", 64'(gq.size()), 64'd1);
        if (gq.size() >= 1) check_val("single_who", 64'(gq[0]), 64'd2);
        check_val("single_lat", 64'(last_resp_c - last_acc_c), 64'd8);
        check_val("single_pc", last_resp_pc, 64'h1004);
        check_val("single_err", 64'(last_resp_err), 64'd0);

        // miss priority over round-robin position
        apply_reset();
        lat_cfg = 3;
        pcs[0] = 64'h2000; pcs[3] = 64'h3000;
        v = 4'b1001; m = 4'b1000;
        repeat (14) step();
        check_val("miss_n", 64'(gq.size()), 64'd2);
        if (gq.size() >= 2) begin
            check_val("miss_first", 64'(gq[0]), 64'd3);
            check_val("miss_second", 64'(gq[1]), 64'd0);
        end

        // round-robin with all requesters continuously asking
        apply_reset();
        lat_cfg = 2; rereq = 1;
        for (int i = 0; i < 4; i++) pcs[i] = 64'h100 * (i + 1);
        v = 4'b1111; m = 4'b0000;
        repeat (23) step();
        rereq = 0; v = '0;
        repeat (6) step();
        check_val("rr_n", 64'(gq.size()), 64'd5);
        if (gq.size() >= 5) begin
            check_val("rr_g0", 64'(gq[0]), 64'd0);
            check_val("rr_g1", 64'(gq[1]), 64'd1);
            check_val("rr_g2", 64'(gq[2]), 64'd2);
            check_val("rr_g3", 64'(gq[3]), 64'd3);
            check_val("rr_g4", 64'(gq[4]), 64'd0);
        end

        // timeout with wrap-around, stray oe pulses while idle
        apply_reset();
        stray_mode = 1; lat_cfg = 0;
        rc0 = resp_count;
        repeat (12) step();
        check_val("stray_noresp", 64'(resp_count - rc0), 64'd0);
        pcs[0] = 64'hFFFF_FFFF_FFFF_FFFC; v = 4'b0001;
        repeat (22) step();
        check_val("to_lat", 64'(last_resp_c - last_acc_c), 64'd17);
        check_val("to_pc", last_resp_pc, 64'd0);
        check_val("to_err", 64'(last_resp_err), 64'd1);
        stray_mode = 0;

        // oe on the timeout cycle wins
        lat_cfg = TIMEOUT; plus4 = 0;
        pcs[1] = 64'h4000; v = 4'b0010;
        repeat (22) step();
        check_val("col_lat", 64'(last_resp_c - last_acc_c), 64'd17);
        check_val("col_err", 64'(last_resp_err), 64'd0);
        check_val("col_pc", last_resp_pc, fire_val);
        plus4 = 1;

        // reset during WAIT: no response afterwards, rr restarts at 0
        lat_cfg = 2;
        pcs[1] = 64'h5000; v = 4'b0010;
        repeat (8) step();
        lat_cfg = 0;
        pcs[1] = 64'h6000; v = 4'b0010;
        repeat (5) step();
        check_val("pre_rst_busy", 64'(pr_pc_curr), 64'h6000);
        #2;
        apply_reset();
        rc0 = resp_count;
        repeat (20) step();
        check_val("rst_noresp", 64'(resp_count - rc0), 64'd0);
        lat_cfg = 1;
        pcs[1] = 64'h7000; pcs[3] = 64'h8000; v = 4'b1010;
        repeat (4) step();
        check_val("rst_rr_n", 64'(gq.size()), 64'd1);
        if (gq.size() >= 1) check_val("rst_rr_who", 64'(gq[0]), 64'd1);
        v = '0;
        repeat (12) step();

        // randomized traffic against the model
        apply_reset();
        rand_mode = 1; stray_mode = 2; plus4 = 0;
        repeat (3000) step();
        rand_mode = 0; stray_mode = 0; v = '0;
        repeat (25) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iu_sched.md
# iu_sched

Request scheduler that shares one multi-cycle PC-prediction unit among `NREQ` fetch requesters (harts). It arbitrates incoming prediction requests and sequences each one through the predictor's start/compute/output phases. It returns the predicted PC to the owning requester, and substitutes a fallback prediction if the predictor fails to answer within a timeout. The block sits between the per-hart fetch front-ends and the single predictor instance.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, range 2..8.
- `XLEN`, default 64: PC width.
- `TIMEOUT`, default 15: maximum number of WAIT cycles before fallback, range 1..255.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester request.
- `req_miss`  in  NREQ  request is a redirect after a mispredict.
- `req_pc`  in  NREQ*XLEN  current PC per requester; slice i is bits [i*XLEN +: XLEN].
- `req_ready`  out  NREQ  one-hot grant. It is high in the cycle a request is accepted.
- `resp_valid`  out  NREQ  one-hot, one-cycle response strobe.
- `resp_pc`  out  XLEN  predicted PC, valid only while any `resp_valid` bit is high.
- `resp_err`  out  1  the response is a timeout fallback.
- `pr_start`  out  1  one-cycle start pulse to the predictor.
- `pr_miss`  out  1  latched miss flag, held stable from ISSUE through WAIT.
- `pr_pc_curr`  out  XLEN  latched PC, held stable from ISSUE through WAIT.
- `pr_pc_pre`  in  XLEN  predictor result.
- `pr_pc_pre_oe`  in  1  predictor result valid.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. The encoding is one-hot.
- **IDLE:** if any `req_valid` bit is set, select a winner:
  - Requests with `req_miss` set have strict priority over requests without it.
  - Within the chosen class, select round-robin, starting the search at pointer `rr` and scanning upward modulo `NREQ`.
  - `req_ready[winner]` is high that cycle (combinational from state and inputs).
  - On the same edge, latch `owner`, `req_pc[owner]` and `req_miss[owner]`, then go to ISSUE.
  - With no requests, stay in IDLE.
- **ISSUE:** `pr_start=1` for exactly one cycle, then go to WAIT.
- **WAIT:** `cnt` (8 bits) is cleared on entry and increments every WAIT cycle.
  - If `pr_pc_pre_oe=1`, capture `pr_pc_pre` and set `err=0`, then go to RESP.
  - Otherwise, if `cnt == TIMEOUT-1`, set the captured PC to latched pc + 4, with the sum taken modulo 2^XLEN. Set `err=1` and go to RESP.
  - If `oe` arrives in the same cycle as the timeout, `oe` wins.
- **RESP:** drive `resp_valid[owner]=1`, `resp_pc` and `resp_err` for one cycle. Set `rr = (owner+1) mod NREQ`, then go to IDLE.
- **Ignored inputs:**
  - `pr_pc_pre_oe` outside WAIT is ignored, and no response is generated for it.
  - `req_valid` outside IDLE is ignored; `req_ready` stays 0.
- **Request holding:** requesters hold `req_valid`/`req_pc` until they see `req_ready`. A dropped request is simply not served.
- **Reset** (asynchronous, any state):
  - state=IDLE, `rr=0`, `cnt=0`, latched pc=0, `owner=0`.
  - All outputs read 0: `req_ready`, `resp_valid`, `resp_pc`, `resp_err`, `pr_start`, `pr_miss`, `pr_pc_curr`.
  - Any in-flight request is discarded and no response is issued for it.

## Timing
- Accept at cycle t (IDLE), `pr_start` at t+1, WAIT begins at t+2.
- If `oe` is first seen at cycle w ≥ t+2, `resp_valid` is high at w+1.
- Minimum accept-to-response latency is 3 cycles.
- Timeout response is at t+2+TIMEOUT.
- The earliest next accept is the cycle after RESP. Throughput is at most one request per 4 cycles.
- `pr_pc_curr` and `pr_miss` are stable from t+1 until RESP ends, then are driven to 0 in IDLE.
- `resp_pc`/`resp_err` are 0 whenever no `resp_valid` bit is high.

## Test plan
- **Single request:** NREQ=4, WORK=6 stub predictor returning pc+4. Requester 2 requests pc=0x1000, miss=0 at cycle t → `req_ready=4'b0100` at t; `pr_start` at t+1; `oe` at t+7 gives `resp_valid=4'b0100`, `resp_pc=0x1004`, `resp_err=0` at t+8.
- **Miss priority:** requesters 0 (miss=0) and 3 (miss=1) request together with rr=0 → 3 granted first; 0 granted at the first IDLE after 3's RESP.
- **Round-robin:** all four request continuously, none with miss, stub returns in 2 cycles → grant order 0,1,2,3,0. No requester is granted twice before the others are served.
- **Timeout:** stub never asserts `oe`, TIMEOUT=15, pc=0xFFFF_FFFF_FFFF_FFFC → response at t+17 with `resp_err=1` and `resp_pc=0x0` (wrap-around); stray `oe` pulses in IDLE produce no response.
- **Reset mid-WAIT:** assert `rst_n=0` asynchronously during WAIT → all outputs are 0 immediately, and no `resp_valid` occurs after release. The next request is granted starting from rr=0.
- **oe/timeout collision:** `oe` in the same cycle as the timeout → `resp_err=0`, and `resp_pc` equals `pr_pc_pre`.
